// File: rtl/bchecc_gfmult_array.sv
// Time-multiplexed bank of GF(2^M) multipliers: N lanes through P multipliers over K=N/P beats.
// Optional output register stage on the multipliers when BCHECC_GFMULT_PIPE_EN is defined.
module bchecc_gfmult_array #(
  parameter int             M    = 13,
  parameter logic [M-1:0]   POLY = 13'h001B,
  parameter int             N    = 15,
  parameter int             P    = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [N*M-1:0] data_a_i,
  input  logic [N*M-1:0] data_b_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [N*M-1:0] data_s_o,
  output logic           busy_o
);

  localparam int K  = N / P;
  localparam int KW = (K > 1) ? $clog2(K + 1) : 1;
  localparam int W  = N * M;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Carry-less product, then fold every bit at or above x^M back using x^M = POLY.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] prod;
    logic [2*M-2:0] modp;
    prod = '0;
    modp = {{(M-2){1'b0}}, 1'b1, POLY};
    for (int i = 0; i < M; i++)
      if (b[i]) prod = prod ^ ({{(M-1){1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (prod[i]) prod = prod ^ (modp << (i - M));
    return prod[M-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    op_a_q, op_b_q;
  logic [W-1:0]    res_q, res_d;
  logic            feed;
  logic [P*M-1:0]  mul_w;
  logic            wb_en;
  logic [KW-1:0]   wb_idx;
  logic [P*M-1:0]  wb_data;

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign data_s_o    = res_q;

  // The P physical multipliers, fed with the lanes of the current beat.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred on idle beats.
    int lane;
    lane  = 0;
    mul_w = '0;
    feed  = (state_q == CALC) && (k_q < KW'(K));
    if (feed) begin
      for (int p = 0; p < P; p++) begin
        lane = int'(k_q) * P + p;
        mul_w[p*M +: M] = gf_mul(op_a_q[lane*M +: M], op_b_q[lane*M +: M]);
      end
    end
  end

`ifdef BCHECC_GFMULT_PIPE_EN
  localparam logic [KW-1:0] LAST_K = KW'(K);
  logic            pvld_q;
  logic [KW-1:0]   pidx_q;
  logic [P*M-1:0]  pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pvld_q <= 1'b0;
      pidx_q <= '0;
      pipe_q <= '0;
    end else begin
      pvld_q <= feed;
      pidx_q <= k_q;
      pipe_q <= mul_w;
    end
  end

  assign wb_en   = pvld_q;
  assign wb_idx  = pidx_q;
  assign wb_data = pipe_q;
`else
  localparam logic [KW-1:0] LAST_K = KW'(K - 1);

  assign wb_en   = feed;
  assign wb_idx  = k_q;
  assign wb_data = mul_w;
`endif

  // Untouched result slices keep their previous value until their beat writes them.
  always_comb begin
    res_d = res_q;
    if (wb_en)
      for (int p = 0; p < P; p++)
        res_d[(int'(wb_idx) * P + p) * M +: M] = wb_data[p*M +: M];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        state_d = CALC;
        k_d     = '0;
      end
      CALC: begin
        k_d = k_q + 1'b1;
        if (k_q == LAST_K) state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: datapath registers are cleared too, so no partial product can surface after a reset.
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      res_q   <= res_d;
      if (state_q == IDLE && in_valid_i) begin
        op_a_q <= data_a_i;
        op_b_q <= data_b_i;
      end
    end
  end

endmodule
